// File: rtl/e203_trap_pkg.sv
`default_nettype none
// ============================================================================
// Module  : e203_trap_pkg
// Brief   : Shared types, CSR addresses and mcause packing for trap entry.
// Revision: 1.0 - initial release
// ============================================================================
package e203_trap_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_CAP   = 3'd2,
        WR_EPC   = 3'd3,
        WR_CAUSE = 3'd4,
        REDIR    = 3'd5
    } trap_state_e;

    localparam logic [11:0] c_csr_mtvec  = 12'h305;
    localparam logic [11:0] c_csr_mepc   = 12'h341;
    localparam logic [11:0] c_csr_mcause = 12'h342;

    // Interrupt flag lands on the MSB of the CSR word; cause is zero-extended.
    function automatic logic [63:0] mcause_pack(input logic        irq,
                                                input logic [63:0] cause,
                                                input logic [5:0]  msb);
        logic [63:0] v;
        v      = cause;
        v[msb] = irq;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/e203_trap_vec_calc.sv
`default_nettype none
// ============================================================================
// Module  : e203_trap_vec_calc
// Brief   : Trap handler address from mtvec; vector adder only when
//           E203_MTVEC_VECTORED_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module e203_trap_vec_calc
    import e203_trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic [XLEN-1:0]    i_mtvec,
    input  logic               i_irq,
    input  logic [CAUSE_W-1:0] i_cause,
    output logic [XLEN-1:0]    o_target_pc
);

    logic [XLEN-1:0] w_base;

    assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef E203_MTVEC_VECTORED_EN
    logic [XLEN-1:0] w_offset;
    logic            w_vectored;

    // Offset sum is allowed to wrap at the top of the address space.
    assign w_offset    = XLEN'({i_cause, 2'b00});
    assign w_vectored  = i_irq && (i_mtvec[1:0] == 2'b01);
    assign o_target_pc = w_vectored ? (w_base + w_offset) : w_base;
`else
    logic w_unused_ok;

    assign w_unused_ok = ^{i_mtvec[1:0], i_irq, i_cause};
    assign o_target_pc = w_base;
`endif

endmodule
`default_nettype wire

// File: rtl/e203_trap_vec_redirect.sv
`default_nettype none
// ============================================================================
// Module  : e203_trap_vec_redirect
// Brief   : Trap-entry sequencer: reads mtvec, writes mepc/mcause, then
//           redirects the IFU. Option macro: E203_MTVEC_VECTORED_EN.
// Revision: 1.0 - initial release
// ============================================================================
module e203_trap_vec_redirect
    import e203_trap_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int          CAUSE_W    = 4,
    parameter logic [11:0] CSR_MTVEC  = c_csr_mtvec,
    parameter logic [11:0] CSR_MEPC   = c_csr_mepc,
    parameter logic [11:0] CSR_MCAUSE = c_csr_mcause
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trap_valid,
    output logic               trap_ready,
    input  logic               trap_irq,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic [XLEN-1:0]    trap_epc,
    output logic               csr_rd_req,
    output logic [11:0]        csr_rd_addr,
    input  logic [XLEN-1:0]    csr_rd_rdata,
    output logic               csr_wr_en,
    output logic [11:0]        csr_wr_addr,
    output logic [XLEN-1:0]    csr_wr_wdata,
    input  logic               csr_wr_ready,
    output logic               redir_valid,
    input  logic               redir_ready,
    output logic [XLEN-1:0]    redir_pc,
    output logic               busy
);

    trap_state_e        r_state;
    trap_state_e        w_next_state;
    logic               r_irq;
    logic [CAUSE_W-1:0] r_cause;
    logic [XLEN-1:0]    r_epc;
    logic [XLEN-1:0]    r_mtvec;
    logic [XLEN-1:0]    w_mepc;
    logic [XLEN-1:0]    w_mcause;
    logic [XLEN-1:0]    w_handler_pc;
    logic               w_unused_ok;

    assign w_mepc      = {r_epc[XLEN-1:1], 1'b0};
    assign w_mcause    = XLEN'(mcause_pack(r_irq, 64'(r_cause), 6'(XLEN - 1)));
    assign w_unused_ok = r_epc[0];
    assign busy        = (r_state != IDLE);

    e203_trap_vec_calc #(
        .XLEN    (XLEN),
        .CAUSE_W (CAUSE_W)
    ) u_vec_calc (
        .i_mtvec     (r_mtvec),
        .i_irq       (r_irq),
        .i_cause     (r_cause),
        .o_target_pc (w_handler_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq   <= 1'b0;
            r_cause <= '0;
            r_epc   <= '0;
            r_mtvec <= '0;
        end else begin
            if ((r_state == IDLE) && trap_valid) begin
                r_irq   <= trap_irq;
                r_cause <= trap_cause;
                r_epc   <= trap_epc;
            end
            // Read data arrives the cycle after the request strobe.
            if (r_state == RD_CAP) begin
                r_mtvec <= csr_rd_rdata;
            end
        end
    end

    // Write address/data stay zero outside the two write states so the CSR
    // file never sees a stray target.
    always_comb begin
        w_next_state = r_state;
        trap_ready   = 1'b0;
        csr_rd_req   = 1'b0;
        csr_rd_addr  = '0;
        csr_wr_en    = 1'b0;
        csr_wr_addr  = '0;
        csr_wr_wdata = '0;
        redir_valid  = 1'b0;
        redir_pc     = '0;
        case (r_state)
            IDLE: begin
                trap_ready = !rst;
                if (trap_valid) begin
                    w_next_state = RD_REQ;
                end
            end
            RD_REQ: begin
                csr_rd_req   = 1'b1;
                csr_rd_addr  = CSR_MTVEC;
                w_next_state = RD_CAP;
            end
            RD_CAP: begin
                w_next_state = WR_EPC;
            end
            WR_EPC: begin
                csr_wr_en    = 1'b1;
                csr_wr_addr  = CSR_MEPC;
                csr_wr_wdata = w_mepc;
                if (csr_wr_ready) begin
                    w_next_state = WR_CAUSE;
                end
            end
            WR_CAUSE: begin
                csr_wr_en    = 1'b1;
                csr_wr_addr  = CSR_MCAUSE;
                csr_wr_wdata = w_mcause;
                if (csr_wr_ready) begin
                    w_next_state = REDIR;
                end
            end
            REDIR: begin
                redir_valid = 1'b1;
                redir_pc    = w_handler_pc;
                if (redir_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_e203_trap_vec_redirect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_e203_trap_vec_redirect
// Brief   : Directed and stalled-random bench for the trap-entry sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_e203_trap_vec_redirect;
    import e203_trap_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        trap_valid;
    logic        trap_ready;
    logic        trap_irq;
    logic [3:0]  trap_cause;
    logic [31:0] trap_epc;
    logic        csr_rd_req;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_rdata;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_wdata;
    logic        csr_wr_ready;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        busy;

    logic [31:0] tb_mtvec;
    int          checks = 0;
    int          errors = 0;

    e203_trap_vec_redirect dut (
        .clk          (clk),
        .rst          (rst),
        .trap_valid   (trap_valid),
        .trap_ready   (trap_ready),
        .trap_irq     (trap_irq),
        .trap_cause   (trap_cause),
        .trap_epc     (trap_epc),
        .csr_rd_req   (csr_rd_req),
        .csr_rd_addr  (csr_rd_addr),
        .csr_rd_rdata (csr_rd_rdata),
        .csr_wr_en    (csr_wr_en),
        .csr_wr_addr  (csr_wr_addr),
        .csr_wr_wdata (csr_wr_wdata),
        .csr_wr_ready (csr_wr_ready),
        .redir_valid  (redir_valid),
        .redir_ready  (redir_ready),
        .redir_pc     (redir_pc),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // CSR file read side: data valid only in the cycle after the strobe.
    always @(posedge clk) csr_rd_rdata <= csr_rd_req ? tb_mtvec : 32'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus/observation helper with both ready signals held high.
    task automatic run_trap(input logic irq, input logic [3:0] cause, input logic [31:0] epc,
                            output logic [31:0] mepc, output logic [31:0] mcause,
                            output logic [31:0] pc, output int lat);
        mepc = 32'h0; mcause = 32'h0; pc = 32'h0; lat = -1;
        csr_wr_ready = 1'b1; redir_ready = 1'b1;
        trap_valid = 1'b1; trap_irq = irq; trap_cause = cause; trap_epc = epc;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) trap_valid = 1'b0;
            if (csr_wr_en && csr_wr_addr == 12'h341) mepc = csr_wr_wdata;
            if (csr_wr_en && csr_wr_addr == 12'h342) mcause = csr_wr_wdata;
            if (redir_valid) begin
                pc  = redir_pc;
                lat = c;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; trap_valid = 1'b0; trap_irq = 1'b0; trap_cause = 4'h0; trap_epc = 32'h0;
        csr_wr_ready = 1'b1; redir_ready = 1'b1; tb_mtvec = 32'h0;
        tick(); tick();
        checks++;
        if ({trap_ready, csr_rd_req, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_wdata,
             redir_valid, redir_pc, busy} !== '0)
            begin errors++; $display("FAIL reset_outputs got rdy=%b rd=%b wr=%b wa=%h wd=%h rv=%b pc=%h busy=%b expected all 0",
                trap_ready, csr_rd_req, csr_wr_en, csr_wr_addr, csr_wr_wdata, redir_valid, redir_pc, busy); end
        rst = 1'b0;
        #1;
        checks++;
        if ({trap_ready, busy} !== 2'b10)
            begin errors++; $display("FAIL reset_idle got ready=%b busy=%b expected ready=1 busy=0", trap_ready, busy); end
        tick();
    endtask

    task automatic test_exception;
        tb_mtvec = 32'h8000_0100; csr_wr_ready = 1'b1; redir_ready = 1'b1;
        trap_valid = 1'b1; trap_irq = 1'b0; trap_cause = 4'd2; trap_epc = 32'h2000_0044;
        checks++;
        if (trap_ready !== 1'b1) begin errors++; $display("FAIL exc_accept got %b expected 1", trap_ready); end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) trap_valid = 1'b0;
            checks++;
            case (c)
                1: if ({csr_rd_req, csr_rd_addr, busy} !== {1'b1, 12'h305, 1'b1})
                       begin errors++; $display("FAIL exc_rd_req got req=%b addr=%h busy=%b expected 1 305 1", csr_rd_req, csr_rd_addr, busy); end
                2: if ({csr_rd_req, csr_wr_en} !== 2'b00)
                       begin errors++; $display("FAIL exc_rd_cap got req=%b wr=%b expected 0 0", csr_rd_req, csr_wr_en); end
                3: if ({csr_wr_en, csr_wr_addr, csr_wr_wdata} !== {1'b1, 12'h341, 32'h2000_0044})
                       begin errors++; $display("FAIL exc_mepc got en=%b addr=%h data=%h expected 1 341 20000044", csr_wr_en, csr_wr_addr, csr_wr_wdata); end
                4: if ({csr_wr_en, csr_wr_addr, csr_wr_wdata, redir_valid} !== {1'b1, 12'h342, 32'h0000_0002, 1'b0})
                       begin errors++; $display("FAIL exc_mcause got en=%b addr=%h data=%h rv=%b expected 1 342 00000002 0", csr_wr_en, csr_wr_addr, csr_wr_wdata, redir_valid); end
                5: if ({redir_valid, redir_pc, csr_wr_en} !== {1'b1, 32'h8000_0100, 1'b0})
                       begin errors++; $display("FAIL exc_redir got rv=%b pc=%h wr=%b expected 1 80000100 0", redir_valid, redir_pc, csr_wr_en); end
                default: if ({trap_ready, redir_valid, busy} !== 3'b100)
                       begin errors++; $display("FAIL exc_back_idle got ready=%b rv=%b busy=%b expected 1 0 0", trap_ready, redir_valid, busy); end
            endcase
        end
    endtask

    task automatic test_vectored;
        logic [31:0] mepc, mcause, pc, exp_pc;
        int lat;
        tb_mtvec = 32'h8000_0101;
        run_trap(1'b1, 4'd7, 32'h2000_0101, mepc, mcause, pc, lat);
`ifdef E203_MTVEC_VECTORED_EN
        exp_pc = 32'h8000_011C;
`else
        exp_pc = 32'h8000_0100;
`endif
        checks++;
        if (mcause !== 32'h8000_0007) begin errors++; $display("FAIL vec_mcause got %h expected 80000007", mcause); end
        checks++;
        if (mepc !== 32'h2000_0100) begin errors++; $display("FAIL vec_mepc got %h expected 20000100", mepc); end
        checks++;
        if (pc !== exp_pc) begin errors++; $display("FAIL vec_pc got %h expected %h", pc, exp_pc); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL vec_latency got %0d expected 5", lat); end
        // Exceptions never vector, even with mode bits set.
        run_trap(1'b0, 4'd7, 32'h2000_0200, mepc, mcause, pc, lat);
        checks++;
        if ({mcause, pc} !== {32'h0000_0007, 32'h8000_0100})
            begin errors++; $display("FAIL vec_exc got mcause=%h pc=%h expected 00000007 80000100", mcause, pc); end
        tb_mtvec = 32'hFFFF_FFF1;
`ifdef E203_MTVEC_VECTORED_EN
        exp_pc = 32'h0000_002C;
`else
        exp_pc = 32'hFFFF_FFF0;
`endif
        run_trap(1'b1, 4'd15, 32'h0000_0010, mepc, mcause, pc, lat);
        checks++;
        if ({mcause, pc} !== {32'h8000_000F, exp_pc})
            begin errors++; $display("FAIL vec_wrap got mcause=%h pc=%h expected 8000000f %h", mcause, pc, exp_pc); end
    endtask

    task automatic test_backpressure;
        tb_mtvec = 32'h8000_0200; redir_ready = 1'b1;
        trap_valid = 1'b1; trap_irq = 1'b0; trap_cause = 4'd5; trap_epc = 32'h0000_1000;
        csr_wr_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) trap_valid = 1'b0;
            csr_wr_ready = !(c >= 3 && c <= 5);
            if (c >= 3 && c <= 6) begin
                checks++;
                if ({csr_wr_en, csr_wr_addr, csr_wr_wdata} !== {1'b1, 12'h341, 32'h0000_1000})
                    begin errors++; $display("FAIL bp_hold c=%0d got en=%b addr=%h data=%h expected 1 341 00001000", c, csr_wr_en, csr_wr_addr, csr_wr_wdata); end
            end
            if (c == 7) begin
                checks++;
                if ({csr_wr_en, csr_wr_addr, csr_wr_wdata, redir_valid} !== {1'b1, 12'h342, 32'h0000_0005, 1'b0})
                    begin errors++; $display("FAIL bp_mcause got en=%b addr=%h data=%h rv=%b expected 1 342 00000005 0", csr_wr_en, csr_wr_addr, csr_wr_wdata, redir_valid); end
            end
            if (c == 8) begin
                checks++;
                if ({redir_valid, redir_pc} !== {1'b1, 32'h8000_0200})
                    begin errors++; $display("FAIL bp_redir got rv=%b pc=%h expected 1 80000200", redir_valid, redir_pc); end
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        tb_mtvec = 32'h8000_0300; csr_wr_ready = 1'b1; redir_ready = 1'b1;
        trap_valid = 1'b1; trap_irq = 1'b0; trap_cause = 4'd3; trap_epc = 32'h0000_3000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            case (c)
                1: trap_valid = 1'b0;
                3: begin
                    trap_valid = 1'b1; trap_irq = 1'b1; trap_cause = 4'hB; trap_epc = 32'h0000_4001;
                    checks++;
                    if (trap_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_epc got ready=%b expected 0", trap_ready); end
                end
                4: begin
                    checks++;
                    if ({trap_ready, csr_wr_addr, csr_wr_wdata} !== {1'b0, 12'h342, 32'h0000_0003})
                        begin errors++; $display("FAIL b2b_first_mcause got ready=%b addr=%h data=%h expected 0 342 00000003", trap_ready, csr_wr_addr, csr_wr_wdata); end
                end
                5, 6: begin
                    redir_ready = (c == 6);
                    checks++;
                    if ({trap_ready, redir_valid, redir_pc} !== {1'b0, 1'b1, 32'h8000_0300})
                        begin errors++; $display("FAIL b2b_first_redir c=%0d got ready=%b rv=%b pc=%h expected 0 1 80000300", c, trap_ready, redir_valid, redir_pc); end
                end
                7: begin
                    checks++;
                    if ({trap_ready, redir_valid} !== 2'b10)
                        begin errors++; $display("FAIL b2b_accept got ready=%b rv=%b expected 1 0", trap_ready, redir_valid); end
                end
                8: begin
                    trap_valid = 1'b0;
                    checks++;
                    if ({csr_rd_req, csr_rd_addr} !== {1'b1, 12'h305})
                        begin errors++; $display("FAIL b2b_second_rd got req=%b addr=%h expected 1 305", csr_rd_req, csr_rd_addr); end
                end
                10: begin
                    checks++;
                    if ({csr_wr_addr, csr_wr_wdata} !== {12'h341, 32'h0000_4000})
                        begin errors++; $display("FAIL b2b_second_mepc got addr=%h data=%h expected 341 00004000", csr_wr_addr, csr_wr_wdata); end
                end
                11: begin
                    checks++;
                    if ({csr_wr_addr, csr_wr_wdata} !== {12'h342, 32'h8000_000B})
                        begin errors++; $display("FAIL b2b_second_mcause got addr=%h data=%h expected 342 8000000b", csr_wr_addr, csr_wr_wdata); end
                end
                12: begin
                    checks++;
                    if ({redir_valid, redir_pc} !== {1'b1, 32'h8000_0300})
                        begin errors++; $display("FAIL b2b_second_redir got rv=%b pc=%h expected 1 80000300", redir_valid, redir_pc); end
                end
                default: ;
            endcase
        end
        tick();
    endtask

    task automatic test_reset_mid;
        logic [31:0] mepc, mcause, pc;
        int lat;
        tb_mtvec = 32'h8000_0400; csr_wr_ready = 1'b1; redir_ready = 1'b1;
        trap_valid = 1'b1; trap_irq = 1'b0; trap_cause = 4'd1; trap_epc = 32'h0000_5000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) trap_valid = 1'b0;
        end
        checks++;
        if ({csr_wr_en, csr_wr_addr} !== {1'b1, 12'h342})
            begin errors++; $display("FAIL rstmid_in_cause got en=%b addr=%h expected 1 342", csr_wr_en, csr_wr_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({csr_rd_req, csr_rd_addr, csr_wr_en, csr_wr_addr, csr_wr_wdata, redir_valid, redir_pc, busy, trap_ready}
            !== {1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1})
            begin errors++; $display("FAIL rstmid_idle got rd=%b wr=%b wa=%h wd=%h rv=%b pc=%h busy=%b ready=%b expected zeros ready=1",
                csr_rd_req, csr_wr_en, csr_wr_addr, csr_wr_wdata, redir_valid, redir_pc, busy, trap_ready); end
        tick();
        checks++;
        if ({redir_valid, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_no_redir got rv=%b busy=%b expected 0 0", redir_valid, busy); end
        run_trap(1'b0, 4'd6, 32'h0000_6000, mepc, mcause, pc, lat);
        checks++;
        if ({mepc, mcause, pc} !== {32'h0000_6000, 32'h0000_0006, 32'h8000_0400} || lat !== 5)
            begin errors++; $display("FAIL rstmid_after got mepc=%h mcause=%h pc=%h lat=%0d expected 00006000 00000006 80000400 5", mepc, mcause, pc, lat); end
    endtask

    task automatic test_random_stalls;
        logic        irq, done, bad;
        logic [3:0]  cause;
        logic [31:0] epc, mepc, mcause, pc, e_pc, base;
        for (int t = 0; t < 1000; t++) begin
            irq = 1'($urandom_range(0, 1)); cause = 4'($urandom_range(0, 15));
            epc = $urandom; tb_mtvec = $urandom;
            if (t % 4 == 0) tb_mtvec = {tb_mtvec[31:2], 2'b01};
            base = {tb_mtvec[31:2], 2'b00};
            e_pc = base;
`ifdef E203_MTVEC_VECTORED_EN
            if (irq && tb_mtvec[1:0] == 2'b01) e_pc = base + {26'h0, cause, 2'b00};
`endif
            mepc = 32'h0; mcause = 32'h0; pc = 32'h0; done = 1'b0;
            trap_irq = irq; trap_cause = cause; trap_epc = epc;
            for (int c = 0; c < 200 && !done; c++) begin
                trap_valid   = (c == 0);
                csr_wr_ready = ($urandom_range(0, 3) != 0);
                redir_ready  = ($urandom_range(0, 3) != 0);
                bad = (csr_wr_en && !(dut.r_state inside {WR_EPC, WR_CAUSE})) ||
                      (csr_wr_en && csr_wr_addr == 12'h305) ||
                      (!csr_wr_en && (csr_wr_addr != 12'h0 || csr_wr_wdata != 32'h0));
                checks++;
                if (bad !== 1'b0)
                    begin errors++; $display("FAIL guard t=%0d got en=%b addr=%h data=%h expected guarded write", t, csr_wr_en, csr_wr_addr, csr_wr_wdata); end
                if (csr_wr_en && csr_wr_ready && csr_wr_addr == 12'h341) mepc = csr_wr_wdata;
                if (csr_wr_en && csr_wr_ready && csr_wr_addr == 12'h342) mcause = csr_wr_wdata;
                if (redir_valid && redir_ready) begin pc = redir_pc; done = 1'b1; end
                tick();
            end
            trap_valid = 1'b0;
            checks++;
            if ({done, mepc, mcause, pc} !== {1'b1, {epc[31:1], 1'b0}, {irq, 27'h0, cause}, e_pc})
                begin errors++; $display("FAIL rand_trap t=%0d got done=%b mepc=%h mcause=%h pc=%h expected 1 %h %h %h",
                    t, done, mepc, mcause, pc, {epc[31:1], 1'b0}, {irq, 27'h0, cause}, e_pc); end
            if (!done) break;
        end
        csr_wr_ready = 1'b1; redir_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_exception();
        test_vectored();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_stalls();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
